// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID check: reads sysid words 0 and 1, compares and latches status.
// Define SYSID_CHECK_RETRY_EN to re-run a failed check up to MAX_RETRIES more times.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h518B_C86D,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ID_REQ  = 3'd1;
    localparam logic [2:0] S_ID_WAIT = 3'd2;
    localparam logic [2:0] S_TS_REQ  = 3'd3;
    localparam logic [2:0] S_TS_WAIT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] tmo_cnt;
    logic          auto_pend;
    logic          in_req;
    logic          in_wait;
    logic          tmo_hit;
    logic          go;
    logic          ts_match;
    logic          fin;
    logic          fin_tmo;
    logic          retry_take;

    assign in_req      = (state == S_ID_REQ) || (state == S_TS_REQ);
    assign in_wait     = (state == S_ID_WAIT) || (state == S_TS_WAIT);
    assign tmo_hit     = (in_req || in_wait) && (tmo_cnt >= TMO_LAST);
    assign ts_match    = (avm_readdata == EXPECTED_TS);
    assign avm_read    = in_req;
    assign avm_address = (state == S_TS_REQ) || (state == S_TS_WAIT);

    assign go = ((state == S_IDLE) && (start || auto_pend)) ||
                ((state == S_DONE) && start);

    // An attempt ends on the timestamp response or on any timeout; data beats timeout.
    always_comb begin
        fin     = 1'b0;
        fin_tmo = 1'b0;
        unique case (state)
            S_ID_REQ, S_TS_REQ: begin
                if (avm_waitrequest && tmo_hit) begin
                    fin     = 1'b1;
                    fin_tmo = 1'b1;
                end
            end
            S_ID_WAIT: begin
                if (!avm_readdatavalid && tmo_hit) begin
                    fin     = 1'b1;
                    fin_tmo = 1'b1;
                end
            end
            S_TS_WAIT: begin
                if (avm_readdatavalid) begin
                    fin = 1'b1;
                end else if (tmo_hit) begin
                    fin     = 1'b1;
                    fin_tmo = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef SYSID_CHECK_RETRY_EN
    localparam int RW = $clog2(MAX_RETRIES + 2);

    logic [RW-1:0] retry_cnt;
    logic          fin_fail;

    assign fin_fail   = fin_tmo || !id_ok || !ts_match;
    assign retry_take = fin_fail && (retry_cnt < RW'(MAX_RETRIES));

    always_ff @(posedge clock) begin
        if (reset || go) begin
            retry_cnt <= '0;
        end else if (fin && retry_take) begin
            retry_cnt <= retry_cnt + RW'(1);
        end
    end
`else
    assign retry_take = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            auto_pend   <= AUTO_START;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else if (go) begin
            state       <= S_ID_REQ;
            tmo_cnt     <= '0;
            auto_pend   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
        end else if (fin) begin
            if (state == S_TS_WAIT && avm_readdatavalid) begin
                ts_value <= avm_readdata;
            end
            if (retry_take) begin
                state       <= S_ID_REQ;
                tmo_cnt     <= '0;
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                state       <= S_DONE;
                busy        <= 1'b0;
                done        <= 1'b1;
                timeout_err <= fin_tmo;
                if (!fin_tmo) begin
                    ts_ok <= ts_match;
                end
            end
        end else begin
            if (in_req || in_wait) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
            unique case (state)
                S_ID_REQ: begin
                    if (!avm_waitrequest) state <= S_ID_WAIT;
                end
                S_ID_WAIT: begin
                    if (avm_readdatavalid) begin
                        id_value <= avm_readdata;
                        id_ok    <= (avm_readdata == EXPECTED_ID);
                        state    <= S_TS_REQ;
                        tmo_cnt  <= '0;
                    end
                end
                S_TS_REQ: begin
                    if (!avm_waitrequest) state <= S_TS_WAIT;
                end
                default: ;
            endcase
        end
    end

endmodule
